// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : VGA mode constants and segment-timing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_end;
    } seg_timing_t;

    // 640x480 @ 60 Hz (25 MHz pixel clock)
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;

    // 800x600 @ 60 Hz (40 MHz pixel clock)
    localparam int unsigned VGA800_H_ACTIVE = 800;
    localparam int unsigned VGA800_H_FP     = 40;
    localparam int unsigned VGA800_H_SYNC   = 128;
    localparam int unsigned VGA800_H_BP     = 88;
    localparam int unsigned VGA800_V_ACTIVE = 600;
    localparam int unsigned VGA800_V_FP     = 1;
    localparam int unsigned VGA800_V_SYNC   = 4;
    localparam int unsigned VGA800_V_BP     = 23;

    function automatic seg_timing_t calc_seg(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
        seg_timing_t t;
        t.total      = active + fp + sync + bp;
        t.sync_start = active + fp;
        t.sync_end   = active + fp + sync;
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// vga_timing_gen_if : control inputs and raster outputs of vga_timing_gen
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if #(
    parameter int CW   = 11,
    parameter int FC_W = 16
);
    logic            en;
    logic            resync;
    logic            vga_clk;
    logic            pix_ce;
    logic [CW-1:0]   x_pixel;
    logic [CW-1:0]   y_pixel;
    logic            hsync;
    logic            vsync;
    logic            active_pixels;
    logic            vga_blank_n;
    logic            vga_sync_n;
    logic            line_start;
    logic            frame_start;
    logic [FC_W-1:0] frame_count;

    modport master (
        output en, resync,
        input  vga_clk, pix_ce, x_pixel, y_pixel, hsync, vsync, active_pixels,
               vga_blank_n, vga_sync_n, line_start, frame_start, frame_count
    );

    modport slave (
        input  en, resync,
        output vga_clk, pix_ce, x_pixel, y_pixel, hsync, vsync, active_pixels,
               vga_blank_n, vga_sync_n, line_start, frame_start, frame_count
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen_clk_div.sv
// ============================================================================
// vga_clk_div : free-running pixel divider producing vga_clk and a raw tick
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    output logic      o_vga_clk,
    output logic      o_tick
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] c_D_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] c_D_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] r_d;
    logic [DW-1:0] w_d_nxt;
    logic          r_vga_clk;

    always_comb begin
        w_d_nxt = r_d + 1'b1;
        if (i_clr || (r_d == c_D_LAST)) begin
            w_d_nxt = '0;
        end
    end

    // vga_clk is decoded from the next count so it falls on the same edge the raster moves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d       <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_d       <= w_d_nxt;
            r_vga_clk <= (w_d_nxt >= c_D_HALF);
        end
    end

    assign o_vga_clk = r_vga_clk;
    assign o_tick    = (r_d == c_D_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : parametrised VGA raster timing generator (x/y, syncs, window)
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int CW         = 11,
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int WIN_X0     = 80,
    parameter int WIN_X1     = 559,
    parameter int FC_W       = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vga_timing_gen_if.slave   bus
);
    localparam seg_timing_t c_H = calc_seg(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam seg_timing_t c_V = calc_seg(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] c_H_LAST     = CW'(c_H.total - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(c_V.total - 1);
    localparam logic [CW-1:0] c_HS_START   = CW'(c_H.sync_start);
    localparam logic [CW-1:0] c_HS_END     = CW'(c_H.sync_end);
    localparam logic [CW-1:0] c_VS_START   = CW'(c_V.sync_start);
    localparam logic [CW-1:0] c_VS_END     = CW'(c_V.sync_end);
    localparam logic [CW-1:0] c_WIN_X0     = CW'(WIN_X0);
    localparam logic [CW-1:0] c_WIN_X1     = CW'(WIN_X1);
    localparam logic [CW-1:0] c_V_ACTIVE   = CW'(V_ACTIVE);

    if (WIN_X1 >= H_ACTIVE) begin : g_err_win_x1
        $error("vga_timing_gen: WIN_X1 must be below H_ACTIVE");
    end
    if (WIN_X0 > WIN_X1) begin : g_err_win_order
        $error("vga_timing_gen: WIN_X0 must not exceed WIN_X1");
    end
    if ((c_H.total >= (1 << CW)) || (c_V.total >= (1 << CW))) begin : g_err_totals
        $error("vga_timing_gen: raster totals do not fit in CW bits");
    end
    if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_err_clk_div
        $error("vga_timing_gen: CLK_DIV must be even and at least 2");
    end

    logic            w_tick;
    logic            w_vga_clk;
    logic            w_pix_ce;
    logic            w_x_wrap;
    logic            w_frame_wrap;
    logic [CW-1:0]   w_x_nxt;
    logic [CW-1:0]   w_y_nxt;
    logic            w_hs_nxt;
    logic            w_vs_nxt;
    logic            w_act_nxt;

    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_active;
    logic            r_line_start;
    logic            r_frame_start;
    logic [FC_W-1:0] r_frame_count;

    vga_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (bus.resync),
        .o_vga_clk (w_vga_clk),
        .o_tick    (w_tick)
    );

    assign w_pix_ce = w_tick && bus.en && !bus.resync;

    always_comb begin
        w_x_wrap     = (r_x == c_H_LAST);
        w_frame_wrap = w_x_wrap && (r_y == c_V_LAST);
        w_x_nxt      = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt      = r_y;
        if (w_x_wrap) begin
            w_y_nxt = (r_y == c_V_LAST) ? '0 : r_y + 1'b1;
        end
        // Decode the coordinate about to be loaded so every output moves on one edge
        w_hs_nxt  = ((w_x_nxt >= c_HS_START) && (w_x_nxt < c_HS_END)) ? H_SYNC_POL : !H_SYNC_POL;
        w_vs_nxt  = ((w_y_nxt >= c_VS_START) && (w_y_nxt < c_VS_END)) ? V_SYNC_POL : !V_SYNC_POL;
        w_act_nxt = (w_x_nxt >= c_WIN_X0) && (w_x_nxt <= c_WIN_X1) && (w_y_nxt < c_V_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= !H_SYNC_POL;
            r_vsync       <= !V_SYNC_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else if (bus.resync) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= !H_SYNC_POL;
            r_vsync       <= !V_SYNC_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b1;
            r_frame_count <= r_frame_count + 1'b1;
        end else if (w_pix_ce) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= w_hs_nxt;
            r_vsync       <= w_vs_nxt;
            r_active      <= w_act_nxt;
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign bus.vga_clk       = w_vga_clk;
    assign bus.pix_ce        = w_pix_ce;
    assign bus.x_pixel       = r_x;
    assign bus.y_pixel       = r_y;
    assign bus.hsync         = r_hsync;
    assign bus.vsync         = r_vsync;
    assign bus.active_pixels = r_active;
    assign bus.vga_blank_n   = r_active;
    assign bus.vga_sync_n    = 1'b1;
    assign bus.line_start    = r_line_start;
    assign bus.frame_start   = r_frame_start;
    assign bus.frame_count   = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// tb_vga_timing_gen : directed checks of vga_timing_gen on a 16x10 test raster
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;
    // Test raster: H 8+2+3+3=16, V 6+1+2+1=10, window x=2..5; hsync x=10..12, vsync y=7..8
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_k    = 0;

    vga_timing_gen_if #(.CW(6), .FC_W(4)) if_a ();
    vga_timing_gen_if #(.CW(6), .FC_W(4)) if_b ();

    vga_timing_gen #(
        .CLK_DIV(2), .CW(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .WIN_X0(2), .WIN_X1(5), .FC_W(4)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));

    vga_timing_gen #(
        .CLK_DIV(4), .CW(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .WIN_X0(2), .WIN_X1(5), .FC_W(4)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s k=%0d: observed %0h expected %0h", tag, cur_k, obs, exp);
        end
    endtask

    task automatic chk_scan(input string n, input int div, input bit pol, input int k,
                            input logic [5:0] x, input logic [5:0] y, input logic hs,
                            input logic vs, input logic act, input logic blank,
                            input logic syncn, input logic vclk, input logic ce,
                            input logic ls, input logic fs, input logic [3:0] fc);
        int p, ph, ex, ey;
        p  = k / div;
        ph = k % div;
        ex = p % 16;
        ey = (p / 16) % 10;
        chk({n, "_x"}, x, ex);
        chk({n, "_y"}, y, ey);
        chk({n, "_hsync"}, hs, (ex >= 10 && ex < 13) ? pol : !pol);
        chk({n, "_vsync"}, vs, (ey >= 7 && ey < 9) ? pol : !pol);
        chk({n, "_active"}, act, (ex >= 2 && ex <= 5 && ey < 6) ? 1 : 0);
        chk({n, "_blank_n"}, blank, (ex >= 2 && ex <= 5 && ey < 6) ? 1 : 0);
        chk({n, "_sync_n"}, syncn, 1);
        chk({n, "_vga_clk"}, vclk, (ph >= div / 2) ? 1 : 0);
        chk({n, "_pix_ce"}, ce, (ph == div - 1) ? 1 : 0);
        chk({n, "_line_start"}, ls, (ph == 0 && ex == 0) ? 1 : 0);
        chk({n, "_frame_start"}, fs, (ph == 0 && ex == 0 && ey == 0) ? 1 : 0);
        chk({n, "_frame_count"}, fc, (p / 160) % 16);
    endtask

    initial begin
        int fs_cnt, ls_cnt, first_fs;
        rst = 1'b0;
        if_a.en = 1'b1; if_a.resync = 1'b0;
        if_b.en = 1'b1; if_b.resync = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_x", if_a.x_pixel, 0);
        chk("rst_y", if_a.y_pixel, 0);
        chk("rst_hsync_a", if_a.hsync, 1);
        chk("rst_vsync_a", if_a.vsync, 1);
        chk("rst_hsync_b", if_b.hsync, 0);
        chk("rst_vsync_b", if_b.vsync, 0);
        chk("rst_active", if_a.active_pixels, 0);
        chk("rst_blank_n", if_a.vga_blank_n, 0);
        chk("rst_sync_n", if_a.vga_sync_n, 1);
        chk("rst_vga_clk", if_a.vga_clk, 0);
        chk("rst_strobes", {if_a.line_start, if_a.frame_start, if_a.pix_ce}, 0);
        chk("rst_fc", if_a.frame_count, 0);
        rst = 1'b1;

        // Free-running raster: two-plus frames of A, one-plus frame of B
        for (int k = 1; k <= 744; k++) begin
            tick();
            cur_k = k;
            chk_scan("a", 2, 1'b0, k, if_a.x_pixel, if_a.y_pixel, if_a.hsync, if_a.vsync,
                     if_a.active_pixels, if_a.vga_blank_n, if_a.vga_sync_n, if_a.vga_clk,
                     if_a.pix_ce, if_a.line_start, if_a.frame_start, if_a.frame_count);
            chk_scan("b", 4, 1'b1, k, if_b.x_pixel, if_b.y_pixel, if_b.hsync, if_b.vsync,
                     if_b.active_pixels, if_b.vga_blank_n, if_b.vga_sync_n, if_b.vga_clk,
                     if_b.pix_ce, if_b.line_start, if_b.frame_start, if_b.frame_count);
        end

        // Pause for 37 clk at A (x=4,y=3), d=0
        if_a.en = 1'b0; if_b.en = 1'b0;
        for (int j = 1; j <= 37; j++) begin
            tick();
            cur_k = 744 + j;
            chk("hold_x", if_a.x_pixel, 4);
            chk("hold_y", if_a.y_pixel, 3);
            chk("hold_syncs", {if_a.hsync, if_a.vsync}, 2'b11);
            chk("hold_active", if_a.active_pixels, 1);
            chk("hold_strobes", {if_a.pix_ce, if_a.line_start, if_a.frame_start}, 0);
            chk("hold_vga_clk", if_a.vga_clk, j % 2);
            chk("hold_fc", if_a.frame_count, 2);
        end
        if_a.en = 1'b1; if_b.en = 1'b1;
        #1;
        chk("resume_ce", if_a.pix_ce, 1);
        tick(); cur_k = 782;
        chk("resume_x5", if_a.x_pixel, 5);
        chk("resume_act5", if_a.active_pixels, 1);
        tick(); cur_k = 783;
        chk("resume_x5_hold", if_a.x_pixel, 5);
        tick(); cur_k = 784;
        chk("resume_x6", if_a.x_pixel, 6);
        chk("resume_act6", if_a.active_pixels, 0);

        // Resync mid-hsync, on a cycle where pix_ce would otherwise fire
        repeat (12) tick();
        cur_k = 796;
        chk("pre_resync_x", if_a.x_pixel, 12);
        chk("pre_resync_hsync", if_a.hsync, 0);
        tick(); cur_k = 797;
        if_a.resync = 1'b1; if_b.resync = 1'b1;
        #1;
        chk("resync_ce_blocked", if_a.pix_ce, 0);
        tick(); cur_k = 798;
        if_a.resync = 1'b0; if_b.resync = 1'b0;
        chk("resync_xy", {if_a.x_pixel, if_a.y_pixel}, 0);
        chk("resync_syncs", {if_a.hsync, if_a.vsync}, 2'b11);
        chk("resync_active", if_a.active_pixels, 0);
        chk("resync_vga_clk", if_a.vga_clk, 0);
        chk("resync_fs", if_a.frame_start, 1);
        chk("resync_ls", if_a.line_start, 0);
        chk("resync_fc", if_a.frame_count, 3);
        chk("resync_b_fs", if_b.frame_start, 1);
        tick(); cur_k = 799;
        chk("post_resync_fs", if_a.frame_start, 0);
        chk("post_resync_x", if_a.x_pixel, 0);
        chk("post_resync_ce", if_a.pix_ce, 1);
        chk("post_resync_vga_clk", if_a.vga_clk, 1);
        tick(); cur_k = 800;
        chk("post_resync_x1", if_a.x_pixel, 1);

        // 13 more frames: frame_count 3 -> 16 wraps to 0
        fs_cnt = 0; ls_cnt = 0;
        for (int j = 3; j <= 4160; j++) begin
            tick();
            cur_k = 798 + j;
            if (if_a.frame_start) fs_cnt++;
            if (if_a.line_start) ls_cnt++;
            if (j == 4159) chk("fc_before_wrap", if_a.frame_count, 15);
        end
        chk("fs_wrap_pulse", if_a.frame_start, 1);
        chk("fc_wrapped", if_a.frame_count, 0);
        chk("fs_pulse_count", fs_cnt, 13);
        chk("ls_pulse_count", ls_cnt, 130);

        // Asynchronous reset in the middle of hsync
        repeat (25) tick();
        chk("pre_rst_x", if_a.x_pixel, 12);
        chk("pre_rst_hsync", if_a.hsync, 0);
        chk("pre_rst_vga_clk", if_a.vga_clk, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_xy", {if_a.x_pixel, if_a.y_pixel}, 0);
        chk("arst_hsync", if_a.hsync, 1);
        chk("arst_vsync", if_a.vsync, 1);
        chk("arst_active", {if_a.active_pixels, if_a.vga_blank_n}, 0);
        chk("arst_sync_n", if_a.vga_sync_n, 1);
        chk("arst_vga_clk", if_a.vga_clk, 0);
        chk("arst_fc", if_a.frame_count, 0);
        chk("arst_b_hsync", if_b.hsync, 0);
        tick();
        rst = 1'b1;
        first_fs = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            cur_k = k;
            if (if_a.frame_start && first_fs < 0) begin
                first_fs = k;
                chk("first_frame_fc", if_a.frame_count, 1);
            end
        end
        chk("first_frame_start_k", first_fs, 320);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator that replaces the fixed 640x480 driver. Used by all display pipelines on DE2-115.
- Generates a pixel clock and pixel strobe from the system clock, plus x/y counters, sync pulses with configurable polarity, and a cropped active window. Also provides line/frame start strobes, a frame counter, pause and resynchronisation controls.
- Sits between the 50 MHz clock domain and the pixel renderer / ADV7123 DAC pins.

Parameters:
- CLK_DIV, 2: clk cycles per pixel; even, >=2.
- CW, 11: x/y counter width.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch (pixels).
- H_SYNC, 96: hsync width (pixels).
- H_BP, 48: horizontal back porch (pixels).
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch (lines).
- V_SYNC, 2: vsync width (lines).
- V_BP, 33: vertical back porch (lines).
- H_SYNC_POL, 0: asserted level of hsync.
- V_SYNC_POL, 0: asserted level of vsync.
- WIN_X0, 80: first x of draw window (inclusive).
- WIN_X1, 559: last x of draw window (inclusive).
- FC_W, 16: frame counter width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; low freezes raster.
- resync  in  1  synchronous restart of raster to (0,0).
- vga_clk  out  1  divided pixel clock to DAC.
- pix_ce  out  1  one-clk strobe; raster advances on this cycle.
- x_pixel  out  CW  current x.
- y_pixel  out  CW  current y.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- active_pixels  out  1  inside draw window.
- vga_blank_n  out  1  equals active_pixels.
- vga_sync_n  out  1  constant 1.
- line_start  out  1  one-clk pulse when x wraps to 0.
- frame_start  out  1  one-clk pulse when (x,y) wraps to (0,0).
- frame_count  out  FC_W  completed frames, wraps.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters run 0..H_TOTAL-1 and 0..V_TOTAL-1.
- Divider d counts 0..CLK_DIV-1 continuously, including while en is low.
- pix_ce = (d==CLK_DIV-1) && en && !resync.
- vga_clk is a register, high while d >= CLK_DIV/2. The raster updates when vga_clk falls, so it is stable at each vga_clk rising edge.
- On a pix_ce cycle:
  - x <= x+1; at H_TOTAL-1, x <= 0 and y advances.
  - y wraps at V_TOTAL-1.
  - hsync, vsync and active_pixels are registered from the decode of the NEXT (x,y), so all outputs change on the same clk edge.
- Decode rules:
  - hsync asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - active_pixels = WIN_X0 <= x <= WIN_X1 && y < V_ACTIVE.
- line_start and frame_start are registered, asserted for exactly the one clk following the pix_ce that loads x=0, or (0,0) respectively.
- frame_count increments with frame_start and wraps modulo 2^FC_W.
- en low:
  - x, y, syncs, active and frame_count hold.
  - No strobes are generated.
  - vga_clk keeps toggling.
- resync high (sync, 1 clk):
  - x=y=0 and d=0; vga_clk=0.
  - Syncs deasserted, active=0; frame_start pulses next clk.
  - frame_count is NOT cleared.
  - resync has priority over en and over pix_ce.
- Reset (any time, async):
  - x=y=0, d=0, vga_clk=0.
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL.
  - active_pixels=0, vga_blank_n=0, vga_sync_n=1.
  - line_start=0, frame_start=0, frame_count=0.
  - Outputs for pixel (0,0) of the first frame after reset or resync stay at reset levels (documented one-pixel artefact).
- Elaboration checks: WIN_X1 < H_ACTIVE, WIN_X0 <= WIN_X1, totals < 2^CW, CLK_DIV even.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 timing constants (default set) and an 800x600 set.
  - Function computing total and sync-start/end from the four segment parameters.
- Sub-module vga_clk_div (CLK_DIV): produces d-based vga_clk and the raw strobe, and accepts the resync clear.

Test Plan:
- Defaults, en=1, 1 frame -> frame_start pulses 840000 clk apart. hsync low exactly for x=656..751 (96 px). vsync low for y=490..491. Line period 1600 clk.
- Defaults -> active_pixels high x=80..559 on y=0..479, 480 px per line, low for all y>=480. vga_blank_n identical. vga_sync_n=1 always.
- H_SYNC_POL=1, V_SYNC_POL=1 -> hsync/vsync idle low, pulse high in the same windows.
- Drop en for 37 clk at x=300,y=100 -> x/y/syncs frozen, vga_clk toggling. Resume continues from x=300 with no skipped or duplicate pixel.
- Assert resync at x=700,y=400 with frame_count=5 -> next clk x=y=0. frame_start pulses once, frame_count=6, next pixel x=1 after 2 clk.
- Async rst low mid-hsync (x=700) -> all outputs at reset values immediately, without waiting for a clk edge. Release -> first frame_start after 840000 clk, frame_count=1.
